// File: rtl/axil_trng_csr_pkg.sv
// Shared constants for the TRNG AXI4-Lite register block: register word
// indices, CTRL bit positions, response code and a byte-strobe mask helper.
package axil_trng_csr_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_CFG       = 3'd1;
  localparam logic [2:0] REG_SCRATCH   = 3'd2;
  localparam logic [2:0] REG_RESERVED  = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_RNG_DATA  = 3'd5;
  localparam logic [2:0] REG_POP_COUNT = 3'd6;
  localparam logic [2:0] REG_ID        = 3'd7;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Expand 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axil_trng_csr_regfile.sv
// RW register storage, byte-strobe masking, CTRL clear pulse and the pop
// counter. Macro AXIL_TRNG_CSR_WSTRB_EN enables per-byte write strobes;
// without it every write updates the full word and WSTRB is ignored.
module axil_trng_csr_regfile
  import axil_trng_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        pop,
  output logic        ctrl_en,
  output logic [31:0] cfg,
  output logic [31:0] scratch,
  output logic [31:0] reserved,
  output logic [31:0] pop_count,
  output logic        clr
);

  logic [31:0] mask;
  logic        clr_req;

`ifdef AXIL_TRNG_CSR_WSTRB_EN
  assign mask    = strb_to_mask(wr_strb);
  assign clr_req = wr_en && (wr_idx == REG_CTRL) && wr_data[CTRL_CLR_BIT] && wr_strb[0];
`else
  logic unused_strb;
  assign unused_strb = ^wr_strb;
  assign mask        = '1;
  assign clr_req     = wr_en && (wr_idx == REG_CTRL) && wr_data[CTRL_CLR_BIT];
`endif

  // RW register writes, merged under the byte mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= 1'b0;
      cfg      <= '0;
      scratch  <= '0;
      reserved <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        REG_CTRL:     if (mask[CTRL_EN_BIT]) ctrl_en <= wr_data[CTRL_EN_BIT];
        REG_CFG:      cfg      <= (cfg      & ~mask) | (wr_data & mask);
        REG_SCRATCH:  scratch  <= (scratch  & ~mask) | (wr_data & mask);
        REG_RESERVED: reserved <= (reserved & ~mask) | (wr_data & mask);
        default: ;
      endcase
    end
  end

  // Clear pulse one cycle after the CTRL write; it outranks a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr       <= 1'b0;
      pop_count <= '0;
    end else begin
      clr <= clr_req;
      if (clr)      pop_count <= '0;
      else if (pop) pop_count <= pop_count + 32'd1;
    end
  end

endmodule

// File: rtl/axil_trng_csr.sv
// AXI4-Lite slave front end for the TRNG: write/read handshakes, read mux
// and pop-on-read of RNG_DATA. Optional macro AXIL_TRNG_CSR_WSTRB_EN
// (handled in the regfile) enables byte-strobe writes.
module axil_trng_csr
  import axil_trng_csr_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] ID_VALUE           = 32'h5452_4E47
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              trng_en_o,
  output logic                              trng_clr_o,
  output logic [31:0]                       cfg_o,
  input  logic [31:0]                       status_i,
  input  logic [31:0]                       rng_data_i,
  input  logic                              rng_valid_i,
  output logic                              rng_pop_o
);

  logic        aw_ready, ar_ready, b_valid, r_valid;
  logic [31:0] r_data, rd_word;
  logic        wr_hs, rd_hs, pop;
  logic [2:0]  wr_idx, rd_idx;
  logic        ctrl_en, clr;
  logic [31:0] cfg, scratch, reserved, pop_count;

  logic unused_in;
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign wr_hs  = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = ar_ready && S_AXI_ARVALID;
  assign pop    = rd_hs && (rd_idx == REG_RNG_DATA) && rng_valid_i;

  // Joint AW/W acceptance pulse and write response hold.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      aw_ready <= S_AXI_AWVALID && S_AXI_WVALID && !b_valid && !aw_ready;
      if (wr_hs)             b_valid <= 1'b1;
      else if (S_AXI_BREADY) b_valid <= 1'b0;
    end
  end

  // AR acceptance pulse; read data captured at the handshake edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      ar_ready <= S_AXI_ARVALID && !r_valid && !ar_ready;
      if (rd_hs) begin
        r_valid <= 1'b1;
        r_data  <= rd_word;
      end else if (S_AXI_RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Read mux; RNG_DATA returns zero when the FIFO head is not valid.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CTRL:      rd_word[CTRL_EN_BIT] = ctrl_en;
      REG_CFG:       rd_word = cfg;
      REG_SCRATCH:   rd_word = scratch;
      REG_RESERVED:  rd_word = reserved;
      REG_STATUS:    rd_word = status_i;
      REG_RNG_DATA:  rd_word = rng_valid_i ? rng_data_i : '0;
      REG_POP_COUNT: rd_word = pop_count;
      REG_ID:        rd_word = ID_VALUE;
      default:       rd_word = '0;
    endcase
  end

  axil_trng_csr_regfile u_regfile (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .wr_en     (wr_hs),
    .wr_idx    (wr_idx),
    .wr_data   (S_AXI_WDATA),
    .wr_strb   (S_AXI_WSTRB),
    .pop       (pop),
    .ctrl_en   (ctrl_en),
    .cfg       (cfg),
    .scratch   (scratch),
    .reserved  (reserved),
    .pop_count (pop_count),
    .clr       (clr)
  );

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign trng_en_o     = ctrl_en;
  assign trng_clr_o    = clr;
  assign cfg_o         = cfg;
  assign rng_pop_o     = pop;

endmodule

// File: tb/tb_axil_trng_csr.sv
// Directed bench for axil_trng_csr with queued expected responses.
module tb_axil_trng_csr;

  localparam logic [31:0] ID = 32'h5452_4E47;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        trng_en, trng_clr, rng_valid, rng_pop;
  logic [31:0] cfg, status, rng_data;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned clr_pulses = 0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];
  logic        popped;

  always #5 clk = ~clk;

  // Count clear pulses, sampled mid-cycle.
  always @(negedge clk) if (trng_clr === 1'b1) clr_pulses++;

  axil_trng_csr #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .ID_VALUE           (ID)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .trng_en_o     (trng_en),
    .trng_clr_o    (trng_clr),
    .cfg_o         (cfg),
    .status_i      (status),
    .rng_data_i    (rng_data),
    .rng_valid_i   (rng_valid),
    .rng_pop_o     (rng_pop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(2'b00);
    cycle();
    while (!awready && n < 20) begin cycle(); n++; end
    if (!awready) begin
      check1("aw_timeout", awready, 1'b1);
      awvalid = 1'b0; wvalid = 1'b0;
      void'(bq.pop_back());
      return;
    end
    check1("wready_with_awready", wready, 1'b1);
    cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    check1("bvalid", bvalid, 1'b1);
    check("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
    cycle();
  endtask

  task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] exp,
                          output logic pop_seen);
    int unsigned n;
    n = 0;
    pop_seen = 1'b0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    rq.push_back(exp);
    cycle();
    while (!arready && n < 20) begin cycle(); n++; end
    if (!arready) begin
      check1({tag, "_ar_timeout"}, arready, 1'b1);
      arvalid = 1'b0;
      void'(rq.pop_back());
      return;
    end
    pop_seen = rng_pop;
    cycle();
    arvalid = 1'b0;
    check1({tag, "_rvalid"}, rvalid, 1'b1);
    check(tag, rdata, rq.pop_front());
    check({tag, "_rresp"}, {30'b0, rresp}, 32'd0);
    cycle();
  endtask

  initial begin
    int unsigned clr_before;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; status = 32'h1234_5678; rng_data = '0; rng_valid = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Reset state
    check1("rst_awready", awready, 1'b0);
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_arready", arready, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check1("rst_trng_en", trng_en, 1'b0);
    check1("rst_trng_clr", trng_clr, 1'b0);
    check1("rst_rng_pop", rng_pop, 1'b0);
    check("rst_cfg", cfg, 32'd0);

    // RW registers
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h08, 32'h3, 4'hF);
    axi_write(5'h0C, 32'h4, 4'hF);
    axi_read("rd_ctrl", 5'h00, 32'h1, popped);
    axi_read("rd_cfg", 5'h04, 32'h2, popped);
    axi_read("rd_scratch", 5'h08, 32'h3, popped);
    axi_read("rd_reserved", 5'h0C, 32'h4, popped);
    check1("trng_en_set", trng_en, 1'b1);
    check("cfg_out", cfg, 32'h2);

    // ID and RO write
    axi_read("rd_id", 5'h1C, ID, popped);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
    axi_read("rd_id_after_wr", 5'h1C, ID, popped);
    axi_read("rd_status", 5'h10, 32'h1234_5678, popped);

    // Pop-on-read
    rng_valid = 1'b1; rng_data = 32'hDEAD_BEEF;
    axi_read("rd_rng", 5'h14, 32'hDEAD_BEEF, popped);
    check1("pop_on_valid", popped, 1'b1);
    axi_read("rd_popcnt1", 5'h18, 32'd1, popped);
    rng_valid = 1'b0;
    axi_read("rd_rng_empty", 5'h14, 32'd0, popped);
    check1("no_pop_empty", popped, 1'b0);
    axi_read("rd_popcnt1b", 5'h18, 32'd1, popped);

    // AW without W, then BREADY stall
    awaddr = 5'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check1("aw_alone_no_ready", awready, 1'b0);
    end
    wvalid = 1'b1;
    bq.push_back(2'b00);
    cycle();
    check1("awready_after_w", awready, 1'b1);
    check1("wready_after_w", wready, 1'b1);
    cycle();
    check1("awready_one_cycle", awready, 1'b0);
    check1("bvalid_set", bvalid, 1'b1);
    check("bresp_stall", {30'b0, bresp}, {30'b0, bq.pop_front()});
    for (int i = 0; i < 5; i++) begin
      cycle();
      check1("bvalid_held", bvalid, 1'b1);
      check1("no_second_accept", awready, 1'b0);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    cycle();
    check1("bvalid_cleared", bvalid, 1'b0);
    axi_read("rd_scratch_55", 5'h08, 32'h55, popped);

    // Byte strobes
    axi_write(5'h08, 32'h0, 4'hF);
    axi_write(5'h08, 32'hAABB_CCDD, 4'b0101);
`ifdef AXIL_TRNG_CSR_WSTRB_EN
    axi_read("rd_wstrb", 5'h08, 32'h00BB_00DD, popped);
`else
    axi_read("rd_wstrb", 5'h08, 32'hAABB_CCDD, popped);
`endif

    // Three pops then clear
    rng_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rng_data = 32'h100 + 32'(i);
      axi_read("rd_rng_burst", 5'h14, 32'h100 + 32'(i), popped);
      check1("pop_burst", popped, 1'b1);
    end
    axi_read("rd_popcnt4", 5'h18, 32'd4, popped);
    clr_before = clr_pulses;
    axi_write(5'h00, 32'h2, 4'hF);
    repeat (2) cycle();
    check("clr_pulse_count", clr_pulses - clr_before, 32'd1);
    axi_read("rd_popcnt_cleared", 5'h18, 32'd0, popped);
    axi_read("rd_ctrl_cleared", 5'h00, 32'd0, popped);
    check1("trng_en_cleared", trng_en, 1'b0);

    // Pop in the same cycle as the clear pulse: clear wins
    rng_data = 32'hCAFE_F00D;
    awaddr = 5'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(2'b00);
    cycle();
    check1("coll_awready", awready, 1'b1);
    araddr = 5'h14; arvalid = 1'b1; rready = 1'b1;
    rq.push_back(32'hCAFE_F00D);
    cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    check1("coll_clr", trng_clr, 1'b1);
    check1("coll_pop", rng_pop, 1'b1);
    check1("coll_bvalid", bvalid, 1'b1);
    check("coll_bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
    cycle();
    arvalid = 1'b0;
    check1("coll_rvalid", rvalid, 1'b1);
    check("coll_rdata", rdata, rq.pop_front());
    check1("coll_clr_done", trng_clr, 1'b0);
    cycle();
    axi_read("rd_popcnt_coll", 5'h18, 32'd0, popped);
    rng_valid = 1'b0;

    // Reset with a read response pending
    axi_write(5'h04, 32'h77, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF);
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    rq.push_back(32'h77);
    cycle();
    check1("rst_test_arready", arready, 1'b1);
    cycle();
    arvalid = 1'b0;
    check1("rst_test_rvalid", rvalid, 1'b1);
    check("rst_test_rdata", rdata, rq.pop_front());
    cycle();
    check1("rvalid_held", rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("rst_drops_rvalid", rvalid, 1'b0);
    check("rst_clears_cfg", cfg, 32'd0);
    check1("rst_clears_en", trng_en, 1'b0);
    check("rst_clears_rdata", rdata, 32'd0);
    cycle();
    rst_n = 1'b1; rready = 1'b1;
    cycle();
    axi_read("rd_cfg_after_rst", 5'h04, 32'd0, popped);
    axi_read("rd_popcnt_after_rst", 5'h18, 32'd0, popped);
    axi_read("rd_scratch_after_rst", 5'h08, 32'd0, popped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
